// File: rtl/rgb_pwm_pkg.sv
// Shared mode encodings, default width and phase-offset helper for the RGB breathing PWM engine.
package rgb_pwm_pkg;

  localparam int unsigned DEF_CW = 25;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_TRI  = 2'b01;
  localparam logic [1:0] MODE_SAW  = 2'b10;
  localparam logic [1:0] MODE_MAN  = 2'b11;

  // Start duty of channel idx: idx*phase saturated to the period terminal value.
  function automatic int unsigned phase_init(input int unsigned idx, input int unsigned phase,
                                             input int unsigned period);
    int unsigned v;
    v = idx * phase;
    return (v > period) ? period : v;
  endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: duty/direction ramp update on the period tick and active-low output compare.
// With RGB_PWM_GAMMA_EN the compare uses a squared-duty register against the shared cnt*PERIOD accumulator.
module rgb_pwm_chan
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned   CW     = DEF_CW,
  parameter int unsigned   PERIOD = 3464,
  parameter logic [CW-1:0] INIT   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sync,
  input  logic            tick,
  input  logic            oe,
  input  logic [1:0]      mode,
  input  logic [CW-1:0]   duty,
`ifdef RGB_PWM_GAMMA_EN
  input  logic [2*CW-1:0] acc,
`else
  input  logic [CW-1:0]   cnt,
`endif
  output logic            pwm_n_c,
  output logic            stt
);

  localparam logic [CW-1:0] PER    = CW'(PERIOD);
  localparam logic [CW-1:0] PER_M1 = CW'(PERIOD - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] d_q, d_d;
  logic          dir_q, dir_d;
  logic          stt_q, stt_d;

  // Ramp rules applied once per period; sync reloads the phase offset and discards the tick.
  always_comb begin
    d_d   = d_q;
    dir_d = dir_q;
    stt_d = 1'b0;
    if (sync) begin
      d_d   = INIT;
      dir_d = 1'b1;
    end else if (tick) begin
      case (mode)
        MODE_TRI: begin
          if (dir_q) begin
            if (d_q >= PER) begin
              d_d   = PER_M1;
              dir_d = 1'b0;
              stt_d = 1'b1;
            end else begin
              d_d = d_q + ONE;
            end
          end else if (d_q == '0) begin
            d_d   = ONE;
            dir_d = 1'b1;
          end else begin
            d_d = d_q - ONE;
          end
        end
        MODE_SAW: begin
          dir_d = 1'b1;
          if (d_q >= PER) begin
            d_d   = '0;
            stt_d = 1'b1;
          end else begin
            d_d = d_q + ONE;
          end
        end
        MODE_MAN: begin
          d_d   = (duty > PER) ? PER : duty;
          stt_d = (d_d == PER);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q   <= INIT;
      dir_q <= 1'b1;
      stt_q <= 1'b0;
    end else begin
      d_q   <= d_d;
      dir_q <= dir_d;
      stt_q <= stt_d;
    end
  end

`ifdef RGB_PWM_GAMMA_EN
  localparam logic [2*CW-1:0] INIT_SQ = {CW'(0), INIT} * {CW'(0), INIT};

  logic [2*CW-1:0] sq_q, sq_d;

  // sq tracks d*d; reloading every edge keeps it in step with d.
  always_comb sq_d = {CW'(0), d_d} * {CW'(0), d_d};

  always_ff @(posedge clk) begin
    if (rst) sq_q <= INIT_SQ;
    else     sq_q <= sq_d;
  end

  assign pwm_n_c = oe ? ~(acc < sq_q) : 1'b1;
`else
  assign pwm_n_c = oe ? ~(cnt < d_q) : 1'b1;
`endif

  assign stt = stt_q;

endmodule

// File: rtl/rgb_breath_pwm.sv
// Multi-channel breathing/rainbow PWM: shared period counter feeding CH independent ramp channels.
// Optional square-law output enabled by defining RGB_PWM_GAMMA_EN.
module rgb_breath_pwm
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned CH     = 3,
  parameter int unsigned CW     = DEF_CW,
  parameter int unsigned PERIOD = 3464,
  parameter int unsigned PHASE  = 1155
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             _OE,
  input  logic             SYNC,
  input  logic [2*CH-1:0]  MODE,
  input  logic [CW*CH-1:0] DUTY,
  output logic [CH-1:0]    PWM_N,
  output logic [CH-1:0]    STT
);

  localparam logic [CW-1:0] PER = CW'(PERIOD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  always_comb begin
    tick  = (cnt_q == PER);
    cnt_d = cnt_q + CW'(1);
    if (SYNC || tick) cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

`ifdef RGB_PWM_GAMMA_EN
  localparam logic [2*CW-1:0] PER_W = (2*CW)'(PERIOD);

  logic [2*CW-1:0] acc_q, acc_d;

  // acc == cnt*PERIOD, built by repeated addition instead of a multiplier.
  always_comb acc_d = (SYNC || tick) ? '0 : acc_q + PER_W;

  always_ff @(posedge CLK) begin
    if (RST) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`endif

  for (genvar i = 0; i < CH; i++) begin : g_chan
    rgb_pwm_chan #(
      .CW     (CW),
      .PERIOD (PERIOD),
      .INIT   (CW'(phase_init(i, PHASE, PERIOD)))
    ) u_chan (
      .clk     (CLK),
      .rst     (RST),
      .sync    (SYNC),
      .tick    (tick),
      .oe      (_OE),
      .mode    (MODE[2*i +: 2]),
      .duty    (DUTY[CW*i +: CW]),
`ifdef RGB_PWM_GAMMA_EN
      .acc     (acc_q),
`else
      .cnt     (cnt_q),
`endif
      .pwm_n_c (PWM_N[i]),
      .stt     (STT[i])
    );
  end

endmodule

// File: tb/tb_rgb_breath_pwm.sv
// Self-checking bench for rgb_breath_pwm (PERIOD=7, CH=3, PHASE=3, CW=4) with a cycle-level reference model.
module tb_rgb_breath_pwm;

  localparam int CH     = 3;
  localparam int CW     = 4;
  localparam int PERIOD = 7;
  localparam int PHASE  = 3;

  logic             CLK = 1'b0;
  logic             RST;
  logic             _OE;
  logic             SYNC;
  logic [2*CH-1:0]  MODE;
  logic [CW*CH-1:0] DUTY;
  logic [CH-1:0]    PWM_N;
  logic [CH-1:0]    STT;

  int checks   = 0;
  int failures = 0;

  int          m_cnt;
  int          m_d   [CH];
  logic        m_dir [CH];
  logic [CH-1:0] m_stt;
  int          md, du;

  always #5 CLK = ~CLK;

  rgb_breath_pwm #(.CH(CH), .CW(CW), .PERIOD(PERIOD), .PHASE(PHASE)) dut (
    .CLK   (CLK),
    .RST   (RST),
    ._OE   (_OE),
    .SYNC  (SYNC),
    .MODE  (MODE),
    .DUTY  (DUTY),
    .PWM_N (PWM_N),
    .STT   (STT)
  );

  // Reference model: state after each rising edge, derived from the behavioural rules.
  always @(posedge CLK) begin
    if (RST || SYNC) begin
      m_cnt = 0;
      m_stt = '0;
      for (int i = 0; i < CH; i++) begin
        m_d[i]   = (i * PHASE > PERIOD) ? PERIOD : i * PHASE;
        m_dir[i] = 1'b1;
      end
    end else begin
      m_stt = '0;
      if (m_cnt == PERIOD) begin
        m_cnt = 0;
        for (int i = 0; i < CH; i++) begin
          md = int'(MODE[2*i +: 2]);
          du = int'(DUTY[CW*i +: CW]);
          if (md == 1) begin
            if (m_dir[i]) begin
              if (m_d[i] >= PERIOD) begin m_d[i] = PERIOD - 1; m_dir[i] = 1'b0; m_stt[i] = 1'b1; end
              else m_d[i] = m_d[i] + 1;
            end else if (m_d[i] == 0) begin
              m_d[i] = 1; m_dir[i] = 1'b1;
            end else m_d[i] = m_d[i] - 1;
          end else if (md == 2) begin
            m_dir[i] = 1'b1;
            if (m_d[i] >= PERIOD) begin m_d[i] = 0; m_stt[i] = 1'b1; end
            else m_d[i] = m_d[i] + 1;
          end else if (md == 3) begin
            m_d[i]   = (du > PERIOD) ? PERIOD : du;
            m_stt[i] = (m_d[i] == PERIOD);
          end
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  function automatic logic [CH-1:0] exp_pwm();
    logic [CH-1:0] r;
    r = '1;
    for (int i = 0; i < CH; i++) begin
`ifdef RGB_PWM_GAMMA_EN
      if (_OE && (m_cnt * PERIOD < m_d[i] * m_d[i])) r[i] = 1'b0;
`else
      if (_OE && (m_cnt < m_d[i])) r[i] = 1'b0;
`endif
    end
    return r;
  endfunction

  // Number of low clocks per period produced by duty d.
  function automatic int exp_lows(input int d);
    int n;
    n = 0;
    for (int c = 0; c <= PERIOD; c++) begin
`ifdef RGB_PWM_GAMMA_EN
      if (c * PERIOD < d * d) n++;
`else
      if (c < d) n++;
`endif
    end
    return n;
  endfunction

  // Drives one full period (8 clocks) and measures low clocks and STT pulses per channel.
  task automatic run_period(input logic [2*CH-1:0] mode, input logic [CW*CH-1:0] duty,
                            input int chg_c, input logic [CW*CH-1:0] chg_duty,
                            input logic sync7, input logic rst7,
                            output int lows [CH], output int stts [CH], output logic [CH-1:0] pwm0);
    for (int i = 0; i < CH; i++) begin lows[i] = 0; stts[i] = 0; end
    pwm0 = '1;
    for (int c = 0; c <= PERIOD; c++) begin
      @(negedge CLK);
      if (c == 0) begin RST = 1'b0; SYNC = 1'b0; MODE = mode; DUTY = duty; end
      if (c == chg_c) DUTY = chg_duty;
      if (c == PERIOD) begin SYNC = sync7; RST = rst7; end
      #1;
      if (c == 0) pwm0 = PWM_N;
      for (int i = 0; i < CH; i++) begin
        if (PWM_N[i] === 1'b0) lows[i]++;
        if (STT[i] === 1'b1) stts[i]++;
      end
    end
  endtask

  task automatic test_reset();
    int lows [CH];
    int stts [CH];
    logic [CH-1:0] p0;
    int init_d [CH] = '{0, 3, 6};
    RST = 1'b1; SYNC = 1'b0; _OE = 1'b1; MODE = 6'b010101; DUTY = '0;
    @(negedge CLK);
    @(negedge CLK);
    run_period(6'b010101, '0, -1, '0, 1'b0, 1'b0, lows, stts, p0);
    checks++;
    if (p0 !== 3'b001) begin failures++; $display("FAIL reset_pwm got=%b exp=%b", p0, 3'b001); end
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (lows[i] !== exp_lows(init_d[i]))
        begin failures++; $display("FAIL reset_lows ch%0d got=%0d exp=%0d", i, lows[i], exp_lows(init_d[i])); end
      checks++;
      if (stts[i] !== 0) begin failures++; $display("FAIL reset_stt ch%0d got=%0d exp=0", i, stts[i]); end
    end
  endtask

  task automatic test_triangle();
    int lows [CH];
    int stts [CH];
    logic [CH-1:0] p0;
    int d2 [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 1};
    int d0;
    for (int k = 0; k < 9; k++) begin
      run_period(6'b010101, '0, -1, '0, 1'b0, 1'b0, lows, stts, p0);
      d0 = (k <= 6) ? k + 1 : 13 - k;
      checks++;
      if (lows[2] !== exp_lows(d2[k]))
        begin failures++; $display("FAIL tri_ch2_lows k=%0d got=%0d exp=%0d", k, lows[2], exp_lows(d2[k])); end
      checks++;
      if (stts[2] !== ((k == 1) ? 1 : 0))
        begin failures++; $display("FAIL tri_ch2_stt k=%0d got=%0d exp=%0d", k, stts[2], (k == 1) ? 1 : 0); end
      checks++;
      if (lows[0] !== exp_lows(d0))
        begin failures++; $display("FAIL tri_ch0_lows k=%0d got=%0d exp=%0d", k, lows[0], exp_lows(d0)); end
    end
  endtask

  task automatic test_sawtooth_manual();
    int lows [CH];
    int stts [CH];
    logic [CH-1:0] p0;
    int d0;
    run_period(6'b000010, '0, -1, '0, 1'b1, 1'b0, lows, stts, p0);
    for (int k = 0; k < 9; k++) begin
      run_period(6'b000010, '0, -1, '0, 1'b0, 1'b0, lows, stts, p0);
      d0 = (k < 8) ? k : 0;
      checks++;
      if (lows[0] !== exp_lows(d0))
        begin failures++; $display("FAIL saw_ch0_lows k=%0d got=%0d exp=%0d", k, lows[0], exp_lows(d0)); end
      checks++;
      if (stts[0] !== ((k == 8) ? 1 : 0))
        begin failures++; $display("FAIL saw_ch0_stt k=%0d got=%0d exp=%0d", k, stts[0], (k == 8) ? 1 : 0); end
      checks++;
      if (lows[1] !== exp_lows(3) || lows[2] !== exp_lows(6))
        begin failures++; $display("FAIL hold_lows k=%0d got=%0d,%0d exp=%0d,%0d", k, lows[1], lows[2], exp_lows(3), exp_lows(6)); end
    end
    run_period(6'b000011, 12'h00F, -1, '0, 1'b0, 1'b0, lows, stts, p0);
    checks++;
    if (lows[0] !== exp_lows(1) || stts[0] !== 0)
      begin failures++; $display("FAIL man_delay got=%0d/%0d exp=%0d/0", lows[0], stts[0], exp_lows(1)); end
    run_period(6'b000011, 12'h00F, 3, 12'h004, 1'b0, 1'b0, lows, stts, p0);
    checks++;
    if (lows[0] !== exp_lows(7) || stts[0] !== 1)
      begin failures++; $display("FAIL man_clamp got=%0d/%0d exp=%0d/1", lows[0], stts[0], exp_lows(7)); end
    run_period(6'b000011, 12'h004, -1, '0, 1'b0, 1'b0, lows, stts, p0);
    checks++;
    if (lows[0] !== exp_lows(4) || stts[0] !== 0)
      begin failures++; $display("FAIL man_midchange got=%0d/%0d exp=%0d/0", lows[0], stts[0], exp_lows(4)); end
  endtask

  task automatic test_sync();
    int lows [CH];
    int stts [CH];
    logic [CH-1:0] p0;
    int dset [CH] = '{5, 1, 2};
    int dini [CH] = '{0, 3, 6};
    run_period(6'b111111, 12'h215, -1, '0, 1'b0, 1'b0, lows, stts, p0);
    run_period(6'b111111, 12'h215, 1, 12'hF15, 1'b1, 1'b0, lows, stts, p0);
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (lows[i] !== exp_lows(dset[i]))
        begin failures++; $display("FAIL sync_setup ch%0d got=%0d exp=%0d", i, lows[i], exp_lows(dset[i])); end
    end
    run_period(6'b111111, 12'hF15, -1, '0, 1'b1, 1'b1, lows, stts, p0);
    checks++;
    if (p0 !== 3'b001) begin failures++; $display("FAIL sync_pwm0 got=%b exp=%b", p0, 3'b001); end
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (lows[i] !== exp_lows(dini[i]) || stts[i] !== 0)
        begin failures++; $display("FAIL sync_load ch%0d got=%0d/%0d exp=%0d/0", i, lows[i], stts[i], exp_lows(dini[i])); end
    end
    run_period(6'b111111, 12'hF15, -1, '0, 1'b0, 1'b0, lows, stts, p0);
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (lows[i] !== exp_lows(dini[i]) || stts[i] !== 0)
        begin failures++; $display("FAIL rst_sync ch%0d got=%0d/%0d exp=%0d/0", i, lows[i], stts[i], exp_lows(dini[i])); end
    end
  endtask

  task automatic test_oe();
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      _OE = 1'b0;
      if ($urandom_range(0, 5) == 0) begin MODE = 6'($urandom); DUTY = 12'($urandom); end
      #1;
      checks++;
      if (PWM_N !== 3'b111) begin failures++; $display("FAIL oe_off c=%0d got=%b exp=111", c, PWM_N); end
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      _OE = 1'b1;
      #1;
      checks++;
      if (PWM_N !== exp_pwm() || STT !== m_stt)
        begin failures++; $display("FAIL oe_resume c=%0d got=%b/%b exp=%b/%b", c, PWM_N, STT, exp_pwm(), m_stt); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge CLK);
      _OE  = ($urandom_range(0, 9) != 0);
      SYNC = ($urandom_range(0, 39) == 0);
      RST  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) == 0) MODE = 6'($urandom);
      if ($urandom_range(0, 7) == 0) DUTY = 12'($urandom);
      #1;
      checks++;
      if (PWM_N !== exp_pwm() || STT !== m_stt)
        begin failures++; $display("FAIL random c=%0d got=%b/%b exp=%b/%b", c, PWM_N, STT, exp_pwm(), m_stt); end
    end
    @(negedge CLK);
    RST = 1'b0; SYNC = 1'b0; _OE = 1'b1;
  endtask

`ifdef RGB_PWM_GAMMA_EN
  task automatic test_gamma();
    int lows [CH];
    int stts [CH];
    logic [CH-1:0] p0;
    run_period(6'b111111, 12'h074, -1, '0, 1'b0, 1'b0, lows, stts, p0);
    run_period(6'b111111, 12'h074, -1, '0, 1'b0, 1'b0, lows, stts, p0);
    checks++;
    if (lows[0] !== 3 || lows[1] !== 7 || lows[2] !== 0)
      begin failures++; $display("FAIL gamma_lows got=%0d,%0d,%0d exp=3,7,0", lows[0], lows[1], lows[2]); end
  endtask
`endif

  initial begin
    test_reset();
    test_triangle();
    test_sawtooth_manual();
    test_sync();
    test_oe();
    test_random();
`ifdef RGB_PWM_GAMMA_EN
    test_gamma();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
